// File: rtl/mpx_pkg.sv
// Shared types and helpers for the FM stereo multiplex encoder.
// Provides the mode enum and a signed saturation function.
package mpx_pkg;

    typedef enum logic [1:0] {
        MPX_MONO       = 2'd0,
        MPX_STEREO     = 2'd1,
        MPX_PILOT_ONLY = 2'd2,
        MPX_MUTE       = 2'd3
    } mpx_mode_e;

    // Clamp a wide signed value to the range of a width-bit signed number.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        maxv = (64'sd1 <<< (width - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (width - 1));
        if (value > maxv) begin
            return maxv;
        end else if (value < minv) begin
            return minv;
        end
        return value;
    endfunction

endpackage

// File: rtl/mpx_sine_lut.sv
// Quarter-wave sine ROM, two read ports, one-cycle registered output.
// Ports: clk, addr_a/addr_b (full-cycle phase), sin_a/sin_b (signed sine).
module mpx_sine_lut #(
    parameter int OUT_WIDTH = 16,
    parameter int ADDR_BITS = 10
) (
    input  logic                        clk,
    input  logic [ADDR_BITS-1:0]        addr_a,
    input  logic [ADDR_BITS-1:0]        addr_b,
    output logic signed [OUT_WIDTH-1:0] sin_a,
    output logic signed [OUT_WIDTH-1:0] sin_b
);

    localparam int  N  = 2 ** ADDR_BITS;
    localparam int  QN = N / 4;
    localparam int  IW = ADDR_BITS - 1;
    localparam real PI2 = 6.283185307179586;
    localparam real AMP = (2.0 ** (OUT_WIDTH - 1)) - 1.0;

    // Entries 0..QN inclusive so the quadrant peak is stored exactly.
    logic [OUT_WIDTH-1:0] rom [QN+1];

    for (genvar k = 0; k <= QN; k++) begin : g_rom
        assign rom[k] = OUT_WIDTH'($rtoi(
            AMP * $sin(PI2 * real'(k) / real'(N)) + 0.5));
    end

    function automatic logic signed [OUT_WIDTH-1:0] look(
        input logic [ADDR_BITS-1:0] a
    );
        logic [IW-1:0]        off;
        logic [IW-1:0]        idx;
        logic [OUT_WIDTH-1:0] mag;
        off = {1'b0, a[ADDR_BITS-3:0]};
        // Odd quadrants read the table backwards.
        idx = a[ADDR_BITS-2] ? (IW'(QN) - off) : off;
        mag = rom[idx];
        // Second half-cycle is the negated mirror.
        return a[ADDR_BITS-1] ? -$signed(mag) : $signed(mag);
    endfunction

    always_ff @(posedge clk) begin
        sin_a <= look(addr_a);
        sin_b <= look(addr_b);
    end

endmodule

// File: rtl/stereo_mpx_encoder.sv
// FM stereo MPX encoder: (L+R)/2 + (L-R)/2*sin(2t) + pilot*sin(t).
// Ports: clk, reset(async low), in_l/in_r/in_valid, mode, step, gains,
// phase_clear, sat_clear -> mpx_out, mpx_valid, sat_count.
module stereo_mpx_encoder
    import mpx_pkg::*;
#(
    parameter int IN_WIDTH      = 16,
    parameter int OUT_WIDTH     = 16,
    parameter int PHASE_WIDTH   = 32,
    parameter int LUT_ADDR_BITS = 10,
    parameter int GAIN_WIDTH    = 16,
    parameter int GAIN_RADIX    = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [IN_WIDTH-1:0]  in_l,
    input  logic signed [IN_WIDTH-1:0]  in_r,
    input  logic                        in_valid,
    input  logic [1:0]                  mode,
    input  logic [PHASE_WIDTH-1:0]      step,
    input  logic [GAIN_WIDTH-1:0]       sum_gain,
    input  logic [GAIN_WIDTH-1:0]       diff_gain,
    input  logic [GAIN_WIDTH-1:0]       pilot_gain,
    input  logic                        phase_clear,
    input  logic                        sat_clear,
    output logic signed [OUT_WIDTH-1:0] mpx_out,
    output logic                        mpx_valid,
    output logic [15:0]                 sat_count
);

    localparam int PW  = PHASE_WIDTH;
    localparam int LA  = LUT_ADDR_BITS;
    localparam int SW  = IN_WIDTH + 1;
    localparam int GW1 = GAIN_WIDTH + 1;
    localparam int PS  = SW + GW1;
    localparam int PP  = OUT_WIDTH + GW1;
    localparam int PD  = PS + OUT_WIDTH;
    localparam int TW  = PD + 2;

    logic [PW-1:0] phase;
    logic [3:0]    vld;

    // Stage 1: captured sample and config
    logic signed [SW-1:0]   s1_sum, s1_diff;
    logic [LA-1:0]          s1_addr1, s1_addr2;
    mpx_mode_e              s1_mode;
    logic [GAIN_WIDTH-1:0]  s1_sg, s1_dg, s1_pg;

    // Stage 2: LUT outputs alongside delayed operands
    logic signed [OUT_WIDTH-1:0] s2_sin1, s2_sin2;
    logic signed [SW-1:0]        s2_sum, s2_diff;
    mpx_mode_e                   s2_mode;
    logic [GAIN_WIDTH-1:0]       s2_sg, s2_dg, s2_pg;

    // Stage 3: gained, mode-masked terms
    logic signed [PS-1:0]        s3_sum_s, s3_diff_s;
    logic signed [PP-1:0]        s3_pil;
    logic signed [OUT_WIDTH-1:0] s3_sin2;

    // Stage 4: modulated difference
    logic signed [PS-1:0] s4_sum_s;
    logic signed [PD-1:0] s4_dmod;
    logic signed [PP-1:0] s4_pil;

    logic [PW-1:0]        p_w;
    logic signed [SW-1:0] sum_w, diff_w;
    logic signed [PS-1:0] sum_p, diff_p;
    logic signed [PP-1:0] pil_p;
    logic signed [PD-1:0] dmod_p;
    logic signed [TW-1:0] total;
    logic signed [63:0]   total_x, total_sat;
    logic                 clip;

    always_comb begin
        p_w       = phase_clear ? '0 : phase;
        sum_w     = SW'(in_l) + SW'(in_r);
        diff_w    = SW'(in_l) - SW'(in_r);
        sum_p     = PS'(s2_sum) * PS'($signed({1'b0, s2_sg}));
        diff_p    = PS'(s2_diff) * PS'($signed({1'b0, s2_dg}));
        pil_p     = PP'(s2_sin1) * PP'($signed({1'b0, s2_pg}));
        dmod_p    = PD'(s3_diff_s) * PD'(s3_sin2);
        total     = TW'(s4_sum_s) + TW'(s4_dmod) + TW'(s4_pil);
        total_x   = 64'(total);
        total_sat = sat_signed(total_x, OUT_WIDTH);
        clip      = (total_sat != total_x);
    end

    mpx_sine_lut #(
        .OUT_WIDTH (OUT_WIDTH),
        .ADDR_BITS (LA)
    ) u_lut (
        .clk    (clk),
        .addr_a (s1_addr1),
        .addr_b (s1_addr2),
        .sin_a  (s2_sin1),
        .sin_b  (s2_sin2)
    );

    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_sum   <= sum_w >>> 1;
            s1_diff  <= diff_w >>> 1;
            s1_addr1 <= p_w[PW-1 -: LA];
            s1_addr2 <= p_w[PW-2 -: LA];
            s1_mode  <= mpx_mode_e'(mode);
            s1_sg    <= sum_gain;
            s1_dg    <= diff_gain;
            s1_pg    <= pilot_gain;
        end
        s2_sum  <= s1_sum;
        s2_diff <= s1_diff;
        s2_mode <= s1_mode;
        s2_sg   <= s1_sg;
        s2_dg   <= s1_dg;
        s2_pg   <= s1_pg;
        s3_sin2 <= s2_sin2;
        // Masking the difference term here also removes dmod.
        unique case (s2_mode)
            MPX_MONO: begin
                s3_sum_s  <= sum_p >>> GAIN_RADIX;
                s3_diff_s <= '0;
                s3_pil    <= '0;
            end
            MPX_STEREO: begin
                s3_sum_s  <= sum_p >>> GAIN_RADIX;
                s3_diff_s <= diff_p >>> GAIN_RADIX;
                s3_pil    <= pil_p >>> GAIN_RADIX;
            end
            MPX_PILOT_ONLY: begin
                s3_sum_s  <= '0;
                s3_diff_s <= '0;
                s3_pil    <= pil_p >>> GAIN_RADIX;
            end
            default: begin
                s3_sum_s  <= '0;
                s3_diff_s <= '0;
                s3_pil    <= '0;
            end
        endcase
        s4_sum_s <= s3_sum_s;
        s4_pil   <= s3_pil;
        s4_dmod  <= dmod_p >>> (OUT_WIDTH - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= '0;
            vld       <= '0;
            mpx_out   <= '0;
            mpx_valid <= 1'b0;
            sat_count <= '0;
        end else begin
            if (in_valid) begin
                phase <= p_w + step;
            end else if (phase_clear) begin
                phase <= '0;
            end
            vld       <= {vld[2:0], in_valid};
            mpx_valid <= vld[3];
            if (vld[3]) begin
                mpx_out <= total_sat[OUT_WIDTH-1:0];
            end
            if (sat_clear) begin
                sat_count <= '0;
            end else if (vld[3] && clip && sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stereo_mpx_encoder.sv
// Scoreboard bench for stereo_mpx_encoder.
// Directed vectors push expectations; a monitor pops on mpx_valid.
module tb_stereo_mpx_encoder;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] in_l = '0;
    logic signed [15:0] in_r = '0;
    logic               in_valid = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [31:0]        step = '0;
    logic [15:0]        sum_gain = '0;
    logic [15:0]        diff_gain = '0;
    logic [15:0]        pilot_gain = '0;
    logic               phase_clear = 1'b0;
    logic               sat_clear = 1'b0;
    logic signed [15:0] mpx_out;
    logic               mpx_valid;
    logic [15:0]        sat_count;

    always #5 clk = ~clk;

    stereo_mpx_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_l        (in_l),
        .in_r        (in_r),
        .in_valid    (in_valid),
        .mode        (mode),
        .step        (step),
        .sum_gain    (sum_gain),
        .diff_gain   (diff_gain),
        .pilot_gain  (pilot_gain),
        .phase_clear (phase_clear),
        .sat_clear   (sat_clear),
        .mpx_out     (mpx_out),
        .mpx_valid   (mpx_valid),
        .sat_count   (sat_count)
    );

    typedef struct {
        int    val;
        int    cyc;
        string nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && mpx_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk({e.nm, "_val"}, mpx_out, e.val);
                chk({e.nm, "_lat"}, cyc - e.cyc, 5);
            end
        end
    end

    task automatic issue(input int l, input int r,
                         input logic [1:0] m, input bit pc,
                         input int ev, input string nm,
                         input bit push);
        in_l        = 16'(l);
        in_r        = 16'(r);
        mode        = m;
        phase_clear = pc;
        in_valid    = 1'b1;
        if (push) q.push_back('{val: ev, cyc: cyc, nm: nm});
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        phase_clear = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", mpx_out, 0);
        chk("rst_valid", mpx_valid, 0);
        chk("rst_sat", sat_count, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Pilot alone, quarter-cycle steps
        step       = 32'h4000_0000;
        pilot_gain = 16'h4000;
        issue(0, 0, 2, 0, 0,      "t1_0", 1);
        issue(0, 0, 2, 0, 32767,  "t1_1", 1);
        issue(0, 0, 2, 0, 0,      "t1_2", 1);
        issue(0, 0, 2, 0, -32767, "t1_3", 1);
        drain();

        // Stereo difference on the 38 kHz subcarrier
        step       = 32'h2000_0000;
        sum_gain   = 16'h4000;
        diff_gain  = 16'h4000;
        pilot_gain = 16'h0000;
        issue(1000, -1000, 1, 1, 0,     "t2_0", 1);
        issue(1000, -1000, 1, 0, 999,   "t2_1", 1);
        issue(1000, -1000, 1, 0, 0,     "t2_2", 1);
        issue(1000, -1000, 1, 0, -1000, "t2_3", 1);
        drain();

        // Saturation both ways, then clear colliding with a clip
        sum_gain = 16'h8000;
        issue(32767, 32767, 0, 0, 32767,    "t3_pos", 1);
        issue(-32768, -32768, 0, 0, -32768, "t3_neg", 1);
        drain();
        chk("t3_sat2", sat_count, 2);
        issue(32767, 32767, 0, 0, 32767, "t3_clr", 1);
        repeat (3) @(posedge clk);
        #1;
        sat_clear = 1'b1;
        @(posedge clk);
        #1;
        sat_clear = 1'b0;
        chk("t3_sat_clr", sat_count, 0);
        drain();

        // Phase realignment mid-sequence
        sum_gain   = 16'h0000;
        diff_gain  = 16'h0000;
        pilot_gain = 16'h4000;
        step       = 32'h4000_0000;
        issue(0, 0, 2, 1, 0,     "t4_0", 1);
        issue(0, 0, 2, 0, 32767, "t4_1", 1);
        issue(0, 0, 2, 0, 0,     "t4_2", 1);
        issue(0, 0, 2, 1, 0,     "t4_3", 1);
        issue(0, 0, 2, 0, 32767, "t4_4", 1);
        drain();

        // Reset with a sample in flight
        pilot_gain = 16'h0000;
        sum_gain   = 16'h8000;
        issue(32767, 32767, 0, 0, 32767, "t5_pre", 1);
        drain();
        chk("t5_sat1", sat_count, 1);
        chk("t5_out_pre", mpx_out, 32767);
        issue(32767, 32767, 0, 0, 0, "t5_drop", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_rst_out", mpx_out, 0);
        chk("t5_rst_valid", mpx_valid, 0);
        chk("t5_rst_sat", sat_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_hold_out", mpx_out, 0);

        // Mode change between back-to-back strobes
        sum_gain  = 16'h4000;
        diff_gain = 16'h4000;
        step      = 32'h2000_0000;
        issue(1000, 1000, 1, 1, 1000, "t6_st", 1);
        issue(1000, 1000, 3, 0, 0,    "t6_mute", 1);
        mode     = 2'd1;
        sum_gain = 16'hFFFF;
        drain();

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
